// File: rtl/axi_full_slave_sram.sv
// AXI4 full slave in front of a 2^AW x DW word array (instance i_sram, array ram).
// Optional macro AXI_SRAM_WLAST_CHECK_EN: flag WLAST/beat-count mismatch as SLVERR on B.

module axi_full_slave_sram_mem #(
    parameter int DW = 128,
    parameter int AW = 14,
    parameter int NB = DW / 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [NB-1:0] wstrb,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] ram [0:(2**AW)-1];

    // Byte-masked write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) ram[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = ram[raddr];
endmodule

module axi_full_slave_sram #(
    parameter int DW = 128,
    parameter int AW = 14
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [3:0]      MEM_AWID,
    input  logic [31:0]     MEM_AWADDR,
    input  logic [7:0]      MEM_AWLEN,
    input  logic [2:0]      MEM_AWSIZE,
    input  logic [1:0]      MEM_AWBURST,
    input  logic            MEM_AWVALID,
    output logic            MEM_AWREADY,
    input  logic [DW-1:0]   MEM_WDATA,
    input  logic [DW/8-1:0] MEM_WSTRB,
    input  logic            MEM_WLAST,
    input  logic            MEM_WVALID,
    output logic            MEM_WREADY,
    output logic [3:0]      MEM_BID,
    output logic [1:0]      MEM_BRESP,
    output logic            MEM_BVALID,
    input  logic            MEM_BREADY,
    input  logic [3:0]      MEM_ARID,
    input  logic [31:0]     MEM_ARADDR,
    input  logic [7:0]      MEM_ARLEN,
    input  logic [2:0]      MEM_ARSIZE,
    input  logic [1:0]      MEM_ARBURST,
    input  logic            MEM_ARVALID,
    output logic            MEM_ARREADY,
    output logic [3:0]      MEM_RID,
    output logic [DW-1:0]   MEM_RDATA,
    output logic [1:0]      MEM_RRESP,
    output logic            MEM_RLAST,
    output logic            MEM_RVALID,
    input  logic            MEM_RREADY
);
    localparam int NB  = DW / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] incr;
        logic [31:0] mask;
        incr = addr + (32'd1 << size);
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (incr & mask);
            default: next_addr = incr;
        endcase
    endfunction

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        active_q, active_d;
    logic [3:0]  w_id_q, w_id_d, r_id_q, r_id_d;
    logic [31:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [7:0]  w_len_q, w_len_d, r_len_q, r_len_d;
    logic [7:0]  w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
    logic [2:0]  w_size_q, w_size_d, r_size_q, r_size_d;
    logic [1:0]  w_burst_q, w_burst_d, r_burst_q, r_burst_d;
    logic        awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic        aw_hs_s, w_hs_s, ar_hs_s, r_hs_s, rlast_s;
    logic [1:0]  bresp_s;
    logic [DW-1:0] rdata_s;

    // Holds the ready outputs low until the first edge after reset release
    assign active_d = 1'b1;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            active_q  <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_id_q    <= 4'd0;  w_addr_q <= 32'd0; w_len_q <= 8'd0;
            w_cnt_q   <= 8'd0;  w_size_q <= 3'd0;  w_burst_q <= 2'd0;
            r_id_q    <= 4'd0;  r_addr_q <= 32'd0; r_len_q <= 8'd0;
            r_cnt_q   <= 8'd0;  r_size_q <= 3'd0;  r_burst_q <= 2'd0;
        end else begin
            active_q  <= active_d;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_id_q    <= w_id_d;  w_addr_q <= w_addr_d; w_len_q <= w_len_d;
            w_cnt_q   <= w_cnt_d; w_size_q <= w_size_d; w_burst_q <= w_burst_d;
            r_id_q    <= r_id_d;  r_addr_q <= r_addr_d; r_len_q <= r_len_d;
            r_cnt_q   <= r_cnt_d; r_size_q <= r_size_d; r_burst_q <= r_burst_d;
        end
    end

    always_comb begin
        awready_s = active_q && (w_state_q == W_IDLE);
        wready_s  = (w_state_q == W_DATA);
        bvalid_s  = (w_state_q == W_RESP);
        arready_s = active_q && (r_state_q == R_IDLE);
        rvalid_s  = (r_state_q == R_DATA);
    end

    assign aw_hs_s = awready_s && MEM_AWVALID;
    assign w_hs_s  = wready_s && MEM_WVALID;
    assign ar_hs_s = arready_s && MEM_ARVALID;
    assign r_hs_s  = rvalid_s && MEM_RREADY;
    assign rlast_s = rvalid_s && (r_cnt_q == r_len_q);

    // Burst length comes from the beat counter, not from WLAST
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
            W_DATA:  if (w_hs_s && (w_cnt_q == w_len_q)) w_state_d = W_RESP; else w_state_d = W_DATA;
            W_RESP:  if (MEM_BREADY) w_state_d = W_IDLE; else w_state_d = W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs_s) r_state_d = R_DATA; else r_state_d = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_s) r_state_d = R_IDLE; else r_state_d = R_DATA;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_id_d = w_id_q; w_addr_d = w_addr_q; w_len_d = w_len_q;
        w_cnt_d = w_cnt_q; w_size_d = w_size_q; w_burst_d = w_burst_q;
        if (aw_hs_s) begin
            w_id_d = MEM_AWID; w_addr_d = MEM_AWADDR; w_len_d = MEM_AWLEN;
            w_size_d = MEM_AWSIZE; w_burst_d = MEM_AWBURST; w_cnt_d = 8'd0;
        end else if (w_hs_s) begin
            w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
            w_cnt_d  = w_cnt_q + 8'd1;
        end else begin
            w_cnt_d = w_cnt_q;
        end
    end

    always_comb begin
        r_id_d = r_id_q; r_addr_d = r_addr_q; r_len_d = r_len_q;
        r_cnt_d = r_cnt_q; r_size_d = r_size_q; r_burst_d = r_burst_q;
        if (ar_hs_s) begin
            r_id_d = MEM_ARID; r_addr_d = MEM_ARADDR; r_len_d = MEM_ARLEN;
            r_size_d = MEM_ARSIZE; r_burst_d = MEM_ARBURST; r_cnt_d = 8'd0;
        end else if (r_hs_s) begin
            r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
            r_cnt_d  = r_cnt_q + 8'd1;
        end else begin
            r_cnt_d = r_cnt_q;
        end
    end

`ifdef AXI_SRAM_WLAST_CHECK_EN
    logic w_err_q, w_err_d;

    always_comb begin
        w_err_d = w_err_q;
        if (aw_hs_s) begin
            w_err_d = 1'b0;
        end else if (w_hs_s && (MEM_WLAST != (w_cnt_q == w_len_q))) begin
            w_err_d = 1'b1;
        end else begin
            w_err_d = w_err_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) w_err_q <= 1'b0;
        else       w_err_q <= w_err_d;
    end

    assign bresp_s = bvalid_s ? {w_err_q, 1'b0} : 2'b00;
`else
    logic unused_wlast_s;
    assign unused_wlast_s = MEM_WLAST;
    assign bresp_s        = 2'b00;
`endif

    // Read port sees pre-write contents when both hit the same word in one cycle
    axi_full_slave_sram_mem #(.DW(DW), .AW(AW), .NB(NB)) i_sram (
        .clk   (CLK),
        .we    (w_hs_s),
        .waddr (w_addr_q[AW+OFS-1:OFS]),
        .wdata (MEM_WDATA),
        .wstrb (MEM_WSTRB),
        .raddr (r_addr_q[AW+OFS-1:OFS]),
        .rdata (rdata_s)
    );

    assign MEM_AWREADY = awready_s;
    assign MEM_WREADY  = wready_s;
    assign MEM_BVALID  = bvalid_s;
    assign MEM_BID     = w_id_q;
    assign MEM_BRESP   = bresp_s;
    assign MEM_ARREADY = arready_s;
    assign MEM_RVALID  = rvalid_s;
    assign MEM_RID     = r_id_q;
    assign MEM_RRESP   = 2'b00;
    assign MEM_RLAST   = rlast_s;
    assign MEM_RDATA   = rvalid_s ? rdata_s : {DW{1'b0}};
endmodule

// File: tb/tb_axi_full_slave_sram.sv
// Directed bench for axi_full_slave_sram: reads, bursts, strobes, wrap, stalls, reset abort, WLAST check.
module tb_axi_full_slave_sram;
    logic         clk, rstn;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, arvalid, wlast, wvalid, bready, rready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]   bid, rid;
    logic [1:0]   bresp, rresp;
    logic [127:0] rdata;

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

`ifdef AXI_SRAM_WLAST_CHECK_EN
    localparam logic [1:0] WLAST_RESP = 2'b10;
`else
    localparam logic [1:0] WLAST_RESP = 2'b00;
`endif
    localparam logic [127:0] PRE  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] W5   = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    localparam logic [127:0] W6   = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] W7   = 128'h77777777_77777777_77777777_77777777;

    axi_full_slave_sram dut (
        .CLK(clk), .RSTn(rstn),
        .MEM_AWID(awid), .MEM_AWADDR(awaddr), .MEM_AWLEN(awlen), .MEM_AWSIZE(awsize),
        .MEM_AWBURST(awburst), .MEM_AWVALID(awvalid), .MEM_AWREADY(awready),
        .MEM_WDATA(wdata), .MEM_WSTRB(wstrb), .MEM_WLAST(wlast), .MEM_WVALID(wvalid),
        .MEM_WREADY(wready),
        .MEM_BID(bid), .MEM_BRESP(bresp), .MEM_BVALID(bvalid), .MEM_BREADY(bready),
        .MEM_ARID(arid), .MEM_ARADDR(araddr), .MEM_ARLEN(arlen), .MEM_ARSIZE(arsize),
        .MEM_ARBURST(arburst), .MEM_ARVALID(arvalid), .MEM_ARREADY(arready),
        .MEM_RID(rid), .MEM_RDATA(rdata), .MEM_RRESP(rresp), .MEM_RLAST(rlast),
        .MEM_RVALID(rvalid), .MEM_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd4; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin step(); n++; end
        chk("awready", {127'd0, awready}, 128'd1);
        step();
        awvalid = 1'b0;
        chk("wready_after_aw", {127'd0, wready}, 128'd1);
    endtask

    task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last,
                        input logic final_beat);
        int n;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        while (wready !== 1'b1 && n < 20) begin step(); n++; end
        chk("wready", {127'd0, wready}, 128'd1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
        if (final_beat) chk("bvalid_after_last_w", {127'd0, bvalid}, 128'd1);
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
        int n;
        bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin step(); n++; end
        chk("bvalid", {127'd0, bvalid}, 128'd1);
        chk("bid", {124'd0, bid}, {124'd0, id});
        chk("bresp", {126'd0, bresp}, {126'd0, resp});
        step();
        bready = 1'b0;
        chk("awready_after_b", {127'd0, awready}, 128'd1);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin step(); n++; end
        chk("arready", {127'd0, arready}, 128'd1);
        step();
        arvalid = 1'b0;
        chk("rvalid_after_ar", {127'd0, rvalid}, 128'd1);
    endtask

    task automatic do_r(input logic [3:0] id, input logic toggle);
        int beat, cyc;
        logic hs;
        beat = 0; cyc = 0;
        rready = toggle ? 1'b0 : 1'b1;
        while (beat < exp_q.size() && cyc < 100) begin
            hs = 1'b0;
            if (rvalid === 1'b1) begin
                chk("rdata", rdata, exp_q[beat]);
                chk("rlast", {127'd0, rlast}, {127'd0, (beat == exp_q.size() - 1)});
                chk("rid", {124'd0, rid}, {124'd0, id});
                chk("rresp", {126'd0, rresp}, 128'd0);
                hs = rready;
            end
            step();
            if (hs) beat++;
            if (toggle) rready = ~rready;
            cyc++;
        end
        chk("r_beat_count", beat, exp_q.size());
        rready = 1'b0;
        chk("rvalid_after_last", {127'd0, rvalid}, 128'd0);
        chk("arready_after_last", {127'd0, arready}, 128'd1);
    endtask

    initial begin
        rstn = 1'b0;
        awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
        wdata = 128'd0; wstrb = 16'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

        step(); step(); step();
        chk("rst_awready", {127'd0, awready}, 128'd0);
        chk("rst_arready", {127'd0, arready}, 128'd0);
        chk("rst_bvalid", {127'd0, bvalid}, 128'd0);
        chk("rst_rvalid", {127'd0, rvalid}, 128'd0);
        rstn = 1'b1;
        step();
        chk("post_rst_awready", {127'd0, awready}, 128'd1);
        chk("post_rst_arready", {127'd0, arready}, 128'd1);

        dut.i_sram.ram[0] = PRE;
        do_ar(4'd5, 32'h8000_0000, 8'd0, 2'b01);
        exp_q.delete(); exp_q.push_back(PRE);
        do_r(4'd5, 1'b0);

        do_aw(4'd9, 32'h8000_0010, 8'd3, 2'b01);
        do_w(128'd1, 16'hFFFF, 1'b0, 1'b0);
        do_w(128'd2, 16'hFFFF, 1'b0, 1'b0);
        do_w(128'd3, 16'hFFFF, 1'b0, 1'b0);
        do_w(128'd4, 16'hFFFF, 1'b1, 1'b1);
        do_b(4'd9, 2'b00);
        do_ar(4'd3, 32'h0000_0010, 8'd3, 2'b01);
        exp_q.delete();
        exp_q.push_back(128'd1); exp_q.push_back(128'd2);
        exp_q.push_back(128'd3); exp_q.push_back(128'd4);
        do_r(4'd3, 1'b0);

        do_aw(4'd2, 32'h0000_0050, 8'd0, 2'b01);
        do_w({128{1'b1}}, 16'hFFFF, 1'b1, 1'b1);
        do_b(4'd2, 2'b00);
        do_aw(4'd2, 32'h0000_0050, 8'd0, 2'b01);
        do_w(128'd0, 16'h00FF, 1'b1, 1'b1);
        do_b(4'd2, 2'b00);
        chk("word5_backdoor", dut.i_sram.ram[5], W5);

        // WRAP of 4 x 16 bytes starting at word 2 wraps to words 0 and 1
        do_ar(4'd7, 32'h0000_0020, 8'd3, 2'b10);
        exp_q.delete();
        exp_q.push_back(128'd2); exp_q.push_back(128'd3);
        exp_q.push_back(PRE);    exp_q.push_back(128'd1);
        do_r(4'd7, 1'b0);

        dut.i_sram.ram[6] = W6;
        dut.i_sram.ram[7] = W7;
        do_ar(4'd11, 32'h0000_0000, 8'd7, 2'b01);
        exp_q.delete();
        exp_q.push_back(PRE);    exp_q.push_back(128'd1);
        exp_q.push_back(128'd2); exp_q.push_back(128'd3);
        exp_q.push_back(128'd4); exp_q.push_back(W5);
        exp_q.push_back(W6);     exp_q.push_back(W7);
        do_r(4'd11, 1'b1);

        do_aw(4'd4, 32'h0000_0200, 8'd3, 2'b01);
        do_w(128'hAA, 16'hFFFF, 1'b0, 1'b0);
        do_w(128'hBB, 16'hFFFF, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_awready", {127'd0, awready}, 128'd0);
        chk("mid_rst_wready", {127'd0, wready}, 128'd0);
        chk("mid_rst_bvalid", {127'd0, bvalid}, 128'd0);
        chk("mid_rst_bid", {124'd0, bid}, 128'd0);
        chk("mid_rst_arready", {127'd0, arready}, 128'd0);
        chk("mid_rst_rvalid", {127'd0, rvalid}, 128'd0);
        chk("mid_rst_rdata", rdata, 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        chk("mid_rst_release_awready", {127'd0, awready}, 128'd1);
        for (int i = 0; i < 3; i++) begin
            chk("no_b_after_abort", {127'd0, bvalid}, 128'd0);
            step();
        end

        do_aw(4'd13, 32'h0000_0100, 8'd1, 2'b01);
        do_w(128'hA5A5, 16'hFFFF, 1'b1, 1'b0);
        do_w(128'h5A5A, 16'hFFFF, 1'b0, 1'b1);
        do_b(4'd13, WLAST_RESP);
        do_ar(4'd1, 32'h0000_0100, 8'd1, 2'b01);
        exp_q.delete(); exp_q.push_back(128'hA5A5); exp_q.push_back(128'h5A5A);
        do_r(4'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
